// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
//
// Takes one M-extension operation at a time. It runs a shift-add multiplier
// or a restoring divider for XLEN iterations, then applies a one-cycle
// sign/special-case fix-up. The result is then presented with a one-cycle
// done pulse. Latency is the same for every funct and every operand value.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    request a new operation (sampled only in IDLE)
//   kill     flush; aborts any operation in flight, beats start in IDLE
//   funct    RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a     rs1: multiplicand / dividend
//   op_b     rs2: multiplier / divisor
//   busy     operation in progress (CALC, FIX, DONE)
//   done     one-cycle pulse, result valid in the same cycle
//   result   registered result, held until the next done
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        funct_q;
  logic [XLEN-1:0]   raw_a;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              sign_a;
  logic              sign_b;
  // Multiply: {product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc;

  logic              a_signed;
  logic              b_signed;
  logic [XLEN-1:0]   in_mag_a;
  logic [XLEN-1:0]   in_mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic              b_zero;
  logic [XLEN-1:0]   fix_value;

  assign busy = (state != IDLE);

  // Operand signedness decoded from the incoming funct, so operands can be
  // turned into magnitudes as they are latched.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct)
      3'b001: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010: a_signed = 1'b1;
      3'b100: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default: ;
    endcase
    in_mag_a = (a_signed && op_a[XLEN-1]) ? -op_a : op_a;
    in_mag_b = (b_signed && op_b[XLEN-1]) ? -op_b : op_b;
  end

  // One iteration of each datapath. The multiplier consumes the multiplier
  // LSB-first; the divider produces quotient bits MSB-first. A quotient bit
  // is set when the shifted remainder (XLEN+1 bits) is at least the divisor.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[XLEN-1:0] - mag_b;
    div_next  = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Final value. Sign flags are only ever set for signed operands, so the
  // XOR alone selects negation. The signed overflow case falls out of the
  // magnitude arithmetic (2^(XLEN-1) / 1 with no negation, remainder 0);
  // divide by zero needs explicit handling.
  always_comb begin
    prod      = (sign_a ^ sign_b) ? -acc : acc;
    quo       = acc[XLEN-1:0];
    rem       = acc[2*XLEN-1:XLEN];
    b_zero    = (mag_b == {XLEN{1'b0}});
    fix_value = prod[XLEN-1:0];
    case (funct_q)
      3'b000: fix_value = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011: fix_value = prod[2*XLEN-1:XLEN];
      3'b100: fix_value = b_zero ? {XLEN{1'b1}} : ((sign_a ^ sign_b) ? -quo : quo);
      3'b101: fix_value = b_zero ? {XLEN{1'b1}} : quo;
      3'b110: fix_value = b_zero ? raw_a : (sign_a ? -rem : rem);
      3'b111: fix_value = b_zero ? raw_a : rem;
      default: ;
    endcase
  end

  // Sequencer: latch in IDLE, XLEN iterations in CALC, fix-up in FIX, pulse
  // done in DONE. kill returns to IDLE from anywhere without touching result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      funct_q <= '0;
      raw_a   <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      acc     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            funct_q <= funct;
            raw_a   <= op_a;
            mag_a   <= in_mag_a;
            mag_b   <= in_mag_b;
            sign_a  <= a_signed & op_a[XLEN-1];
            sign_b  <= b_signed & op_b[XLEN-1];
            acc     <= funct[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
            count   <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            acc <= funct_q[2] ? div_next : mul_next;
            if (count == CW'(XLEN - 1)) begin
              state <= FIX;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FIX: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            result <= fix_value;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
